// File: rtl/mmcm_clkdiv_model_pkg.sv
// Shared helpers for the behavioural clock-tree models: phase offset and
// high-phase length of a divided clock, expressed in VCO cycles.
package mmcm_model_pkg;

    // Offset in VCO cycles of a DIV-ratio clock shifted by DEG degrees.
    function automatic int phase_offset(input int deg, input int div);
        return (deg * div) / 360;
    endfunction

    function automatic bit phase_offset_exact(input int deg, input int div);
        return ((deg * div) % 360) == 0;
    endfunction

    // Odd ratios put the extra cycle in the high phase.
    function automatic int hi_cycles(input int div);
        return (div + 1) / 2;
    endfunction

endpackage

// File: rtl/mmcm_clkdiv_model_if.sv
// Bundle of the clock-model outputs as seen by the clock consumers.
interface mmcm_clkdiv_model_if;
    logic clk_1x_90;
    logic clk_2x_0;
    logic mmcm_lock;

    modport master (output clk_1x_90, output clk_2x_0, output mmcm_lock);
    modport slave  (input  clk_1x_90, input  clk_2x_0, input  mmcm_lock);
endinterface

// File: rtl/mmcm_clkdiv_model_div.sv
// One divided clock: phase counter, high-window compare and output flop.
// The counter is held at 0 until run rises so all instances start aligned.
module clk_phase_div
    import mmcm_model_pkg::*;
#(
    parameter int DIV = 16,
    parameter int OFF = 4
) (
    input  logic sysclk,
    input  logic rst,
    input  logic run,
    output logic clk_out
);

    localparam int W = $clog2(DIV);
    localparam int HI = hi_cycles(DIV);
    localparam logic [W:0]   DIV_W   = (W + 1)'(DIV);
    localparam logic [W:0]   SHIFT_W = (W + 1)'(DIV - OFF);
    localparam logic [W:0]   HI_W    = (W + 1)'(HI);
    localparam logic [W-1:0] LAST_W  = W'(DIV - 1);

    logic [W-1:0] ph_q, ph_d;
    logic         out_q, out_d;
    logic [W:0]   rel;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        ph_d = ph_q;
        if (!run || ph_q == LAST_W) begin
            ph_d = '0;
        end else begin
            ph_d = ph_q + W'(1);
        end

        // (ph + DIV - OFF) mod DIV; the sum is below 2*DIV so one subtract suffices.
        rel = {1'b0, ph_q} + SHIFT_W;
        if (rel >= DIV_W) begin
            rel = rel - DIV_W;
        end
        out_d = run && (rel < HI_W);
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            ph_q  <= '0;
            out_q <= 1'b0;
        end else begin
            ph_q  <= ph_d;
            out_q <= out_d;
        end
    end

    assign clk_out = out_q;

endmodule

// File: rtl/mmcm_clkdiv_model.sv
// Cycle-accurate stand-in for IBUFGDS -> MMCME2_BASE -> BUFG: a lock delay
// followed by two divided, phase-offset clocks, all registered on sysclk.
module mmcm_clkdiv_model
    import mmcm_model_pkg::*;
#(
    parameter int DIV0        = 16,
    parameter int PHASE0_DEG  = 90,
    parameter int DIV1        = 8,
    parameter int PHASE1_DEG  = 0,
    parameter int LOCK_CYCLES = 64
) (
    input  logic sysclk,
    input  logic rst,
    output logic clk_1x_90,
    output logic clk_2x_0,
    output logic mmcm_lock
);

    localparam int OFF0 = phase_offset(PHASE0_DEG, DIV0);
    localparam int OFF1 = phase_offset(PHASE1_DEG, DIV1);
    localparam int LW   = $clog2(LOCK_CYCLES + 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);

    if (DIV0 < 2) begin : g_err_div0
        $error("DIV0 must be at least 2");
    end
    if (DIV1 < 2) begin : g_err_div1
        $error("DIV1 must be at least 2");
    end
    if (PHASE0_DEG < 0 || PHASE0_DEG > 359) begin : g_err_phase0
        $error("PHASE0_DEG must be in 0..359");
    end
    if (PHASE1_DEG < 0 || PHASE1_DEG > 359) begin : g_err_phase1
        $error("PHASE1_DEG must be in 0..359");
    end
    if (!phase_offset_exact(PHASE0_DEG, DIV0)) begin : g_err_off0
        $error("PHASE0_DEG*DIV0 is not a multiple of 360");
    end
    if (!phase_offset_exact(PHASE1_DEG, DIV1)) begin : g_err_off1
        $error("PHASE1_DEG*DIV1 is not a multiple of 360");
    end
    if (LOCK_CYCLES < 1) begin : g_err_lock
        $error("LOCK_CYCLES must be at least 1");
    end

    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
    logic          lock_q, lock_d;

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        lock_d     = lock_q;
        if (!lock_q) begin
            lock_cnt_d = lock_cnt_q + LW'(1);
            if (lock_cnt_q == LOCK_LAST) begin
                lock_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            lock_cnt_q <= '0;
            lock_q     <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            lock_q     <= lock_d;
        end
    end

    clk_phase_div #(.DIV(DIV0), .OFF(OFF0)) u_div0 (
        .sysclk  (sysclk),
        .rst     (rst),
        .run     (lock_q),
        .clk_out (clk_1x_90)
    );

    clk_phase_div #(.DIV(DIV1), .OFF(OFF1)) u_div1 (
        .sysclk  (sysclk),
        .rst     (rst),
        .run     (lock_q),
        .clk_out (clk_2x_0)
    );

    assign mmcm_lock = lock_q;

endmodule

// File: tb/tb_mmcm_clkdiv_model.sv
// Self-checking bench: a default-parameter instance and an alternate one
// (DIV1=5, 45 deg on a /16 clock, short lock), checked against spec waveforms.
module tb_mmcm_clkdiv_model;

    logic sysclk = 1'b0;
    logic rst_a  = 1'b1;
    logic rst_b  = 1'b1;

    always #5 sysclk = ~sysclk;

    mmcm_clkdiv_model_if a_if ();
    mmcm_clkdiv_model_if b_if ();

    mmcm_clkdiv_model dut_a (
        .sysclk    (sysclk),
        .rst       (rst_a),
        .clk_1x_90 (a_if.clk_1x_90),
        .clk_2x_0  (a_if.clk_2x_0),
        .mmcm_lock (a_if.mmcm_lock)
    );

    mmcm_clkdiv_model #(
        .DIV0        (16),
        .PHASE0_DEG  (45),
        .DIV1        (5),
        .PHASE1_DEG  (0),
        .LOCK_CYCLES (4)
    ) dut_b (
        .sysclk    (sysclk),
        .rst       (rst_b),
        .clk_1x_90 (b_if.clk_1x_90),
        .clk_2x_0  (b_if.clk_2x_0),
        .mmcm_lock (b_if.mmcm_lock)
    );

    typedef struct packed {
        logic lock;
        logic c1;
        logic c2;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic exp_t observe(input bit use_b);
        exp_t o;
        if (use_b) o = '{lock: b_if.mmcm_lock, c1: b_if.clk_1x_90, c2: b_if.clk_2x_0};
        else       o = '{lock: a_if.mmcm_lock, c1: a_if.clk_1x_90, c2: a_if.clk_2x_0};
        return o;
    endfunction

    // Expected samples for cycles k=1.. after reset release; patterns are MSB-first
    // and start one cycle after lock.
    task automatic push_lock_sequence(input int lock_cycles, input int n_wave,
                                      input logic [15:0] pat1, input int len1,
                                      input logic [15:0] pat2, input int len2);
        for (int k = 1; k <= lock_cycles + n_wave; k++) begin
            exp_t e;
            int   n;
            n = k - lock_cycles;
            e.lock = (k >= lock_cycles);
            e.c1   = 1'b0;
            e.c2   = 1'b0;
            if (n >= 1) begin
                e.c1 = pat1[len1 - 1 - ((n - 1) % len1)];
                e.c2 = pat2[len2 - 1 - ((n - 1) % len2)];
            end
            sb_q.push_back(e);
        end
    endtask

    task automatic drain(input string name, input bit use_b);
        int k = 0;
        while (sb_q.size() > 0) begin
            exp_t e, o;
            @(negedge sysclk);
            k++;
            e = sb_q.pop_front();
            o = observe(use_b);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL %s k=%0d: lock/c1/c2 got %b required %b", name, k, o, e);
            end
        end
    endtask

    task automatic test_reset();
        exp_t o;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(negedge sysclk);
        o = observe(1'b0);
        vectors++;
        if (o !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_a: got %b required 000", o);
        end
        o = observe(1'b1);
        vectors++;
        if (o !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_b: got %b required 000", o);
        end
    endtask

    task automatic test_lock_and_waveform();
        rst_a = 1'b0;
        push_lock_sequence(64, 48, 16'b0000_1111_1111_0000, 16, 16'h00F0, 8);
        drain("lock_wave", 1'b0);
    endtask

    task automatic test_phase();
        int   rises1 = 0;
        int   rises2 = 0;
        exp_t prev, cur;
        bit   lock_lost = 1'b0;
        prev = observe(1'b0);
        for (int i = 0; i < 1600; i++) begin
            @(negedge sysclk);
            cur = observe(1'b0);
            if (!cur.lock) lock_lost = 1'b1;
            if (cur.c2 && !prev.c2) rises2++;
            if (cur.c1 && !prev.c1) begin
                rises1++;
                vectors++;
                if (!(prev.c2 === 1'b1 && cur.c2 === 1'b0)) begin
                    miscompares++;
                    $display("FAIL phase_align i=%0d: clk_2x_0 %b->%b required 1->0", i, prev.c2, cur.c2);
                end
            end
            prev = cur;
        end
        vectors++;
        if (rises1 !== 100) begin
            miscompares++;
            $display("FAIL count_1x: got %0d required 100", rises1);
        end
        vectors++;
        if (rises2 !== 200) begin
            miscompares++;
            $display("FAIL count_2x: got %0d required 200", rises2);
        end
        vectors++;
        if (lock_lost) begin
            miscompares++;
            $display("FAIL lock_hold: got lock drop required steady 1");
        end
    endtask

    task automatic test_mid_reset();
        exp_t o;
        @(negedge sysclk);
        rst_a = 1'b1;
        @(negedge sysclk);
        o = observe(1'b0);
        vectors++;
        if (o !== 3'b000) begin
            miscompares++;
            $display("FAIL mid_reset: got %b required 000", o);
        end
        rst_a = 1'b0;
        push_lock_sequence(64, 32, 16'b0000_1111_1111_0000, 16, 16'h00F0, 8);
        drain("relock_wave", 1'b0);
    endtask

    task automatic test_alt_params();
        rst_b = 1'b0;
        push_lock_sequence(4, 40, 16'b0011_1111_1100_0000, 16, 16'h001C, 5);
        drain("alt_wave", 1'b1);
    endtask

    initial begin
        test_reset();
        test_lock_and_waveform();
        test_phase();
        test_mid_reset();
        test_alt_params();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
